// File: rtl/i2c_pkg.sv
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared types and defaults for the I2C register bank and slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

    localparam int         AW_DEF      = 8;
    localparam logic [7:0] RO_BASE_DEF = 8'hF0;
    localparam logic [7:0] CNT_MAX     = 8'hFF;

    typedef enum logic [0:0] {
        C_IDLE = 1'b0,
        C_DONE = 1'b1
    } cpu_state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_reg_bank_if.sv
// ============================================================================
// Module   : i2c_reg_bank_if
// Brief    : Slave-side strobes and CPU request/ready bus of the register bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface i2c_reg_bank_if #(
    parameter int AW = 8
);
    logic          ld;
    logic [AW-1:0] mm_addr;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          tx_done;
    logic [7:0]    tx_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ready;
    logic [7:0]    cpu_rdata;
    logic          irq_clr;
    logic          irq;
    logic [7:0]    wr_count;
    logic [AW-1:0] ptr;

    modport slave (
        input  ld, mm_addr, rx_done, rx_data, tx_done,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, irq_clr,
        output tx_data, cpu_ready, cpu_rdata, irq, wr_count, ptr
    );

    modport master (
        output ld, mm_addr, rx_done, rx_data, tx_done,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, irq_clr,
        input  tx_data, cpu_ready, cpu_rdata, irq, wr_count, ptr
    );
endinterface

`default_nettype wire

// File: rtl/edge_rise.sv
// ============================================================================
// Module   : edge_rise
// Brief    : One-flop rising-edge detector; a pulse of any width is one event.
// Revision : 1.0
// ============================================================================
`default_nettype none

module edge_rise (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic sig_i,
    output logic      rise_o
);

    logic hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~hist_q;

endmodule

`default_nettype wire

// File: rtl/i2c_reg_bank.sv
// ============================================================================
// Module   : i2c_reg_bank
// Brief    : Byte register bank behind the I2C slave with a CPU access port,
//            auto-incrementing pointer and sticky write interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_reg_bank
    import i2c_pkg::*;
#(
    parameter int            DEPTH   = 256,
    parameter int            AW      = AW_DEF,
    parameter logic [AW-1:0] RO_BASE = RO_BASE_DEF
) (
    input  wire logic       clk,
    input  wire logic       reset,
    i2c_reg_bank_if.slave   bus
);

    logic [2:0]    lvl;
    logic [2:0]    rise;
    logic          ld_ev;
    logic          rx_ev;
    logic          tx_ev;

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;
    logic [AW-1:0] target;
    logic          wr_accept;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    tx_data_q;
    logic [7:0]    cpu_rdata_q;
    logic          irq_q;
    logic [7:0]    wr_count_q;

    cpu_state_e    cpu_state_q;
    cpu_state_e    cpu_state_d;
    logic          cpu_go;
    logic          cpu_ready;

    assign lvl = {bus.tx_done, bus.rx_done, bus.ld};

    generate
        for (genvar g = 0; g < 3; g++) begin : g_edge
            edge_rise u_edge (
                .clk    (clk),
                .reset  (reset),
                .sig_i  (lvl[g]),
                .rise_o (rise[g])
            );
        end
    endgenerate

    assign ld_ev = rise[0];
    assign rx_ev = rise[1];
    assign tx_ev = rise[2];

    // A load in the same cycle as a write retargets that write to mm_addr.
    assign target    = ld_ev ? bus.mm_addr : ptr_q;
    assign wr_accept = rx_ev && (target < RO_BASE);

    always_comb begin
        ptr_d = ptr_q;
        if (rx_ev) begin
            ptr_d = target + AW'(1);
        end else if (ld_ev) begin
            ptr_d = bus.mm_addr + (tx_ev ? AW'(1) : AW'(0));
        end else if (tx_ev) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[target] <= bus.rx_data;
        end else if (cpu_go && bus.cpu_we) begin
            mem_q[bus.cpu_addr] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            tx_data_q   <= 8'd0;
            cpu_rdata_q <= 8'd0;
            irq_q       <= 1'b0;
            wr_count_q  <= 8'd0;
        end else begin
            ptr_q     <= ptr_d;
            tx_data_q <= mem_q[ptr_q];
            if (cpu_go && !bus.cpu_we) begin
                cpu_rdata_q <= mem_q[bus.cpu_addr];
            end
            // An accepted write outranks a simultaneous clear.
            if (wr_accept) begin
                irq_q      <= 1'b1;
                wr_count_q <= bus.irq_clr ? 8'd1 : sat_inc(wr_count_q);
            end else if (bus.irq_clr) begin
                irq_q      <= 1'b0;
                wr_count_q <= 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_state_q <= C_IDLE;
        end else begin
            cpu_state_q <= cpu_state_d;
        end
    end

    always_comb begin
        cpu_state_d = cpu_state_q;
        case (cpu_state_q)
            C_IDLE:  if (bus.cpu_req && !rx_ev) cpu_state_d = C_DONE;
            C_DONE:  cpu_state_d = C_IDLE;
            default: cpu_state_d = C_IDLE;
        endcase
    end

    always_comb begin
        cpu_go    = 1'b0;
        cpu_ready = 1'b0;
        case (cpu_state_q)
            C_IDLE:  cpu_go    = bus.cpu_req && !rx_ev;
            C_DONE:  cpu_ready = 1'b1;
            default: cpu_ready = 1'b0;
        endcase
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.cpu_ready = cpu_ready;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.irq       = irq_q;
    assign bus.wr_count  = wr_count_q;
    assign bus.ptr       = ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_bank.sv
// ============================================================================
// Module   : tb_i2c_reg_bank
// Brief    : Directed and randomized checks of i2c_reg_bank against a
//            cycle-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_reg_bank;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_reg_bank_if #(.AW(8)) bus ();

    i2c_reg_bank #(
        .DEPTH   (256),
        .AW      (8),
        .RO_BASE (8'hF0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stimulus levels for the coming cycle
    logic       s_ld, s_rx, s_tx, s_req, s_we, s_clr;
    logic [7:0] s_mm, s_rxd, s_ca, s_wd;

    // Reference model state
    logic [7:0] m_mem [256];
    bit         m_known [256];
    logic [7:0] m_ptr, m_cnt, m_tx, m_rdata;
    bit         m_tx_k, m_rd_k, m_irq, m_busy, m_last_rd;
    bit         h_ld, h_rx, h_tx;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 8'd0;  m_cnt   = 8'd0;  m_tx = 8'd0; m_rdata = 8'd0;
        m_tx_k = 1'b1;  m_rd_k  = 1'b1;  m_irq = 1'b0; m_busy = 1'b0;
        m_last_rd = 1'b0;
        h_ld = 1'b0; h_rx = 1'b0; h_tx = 1'b0;
    endtask

    task automatic model_step();
        bit         e_ld, e_rx, e_tx;
        logic [7:0] tgt, nptr, otx;
        bit         otx_k;
        e_ld  = s_ld && !h_ld;
        e_rx  = s_rx && !h_rx;
        e_tx  = s_tx && !h_tx;
        tgt   = e_ld ? s_mm : m_ptr;
        otx   = m_mem[m_ptr];
        otx_k = m_known[m_ptr];
        nptr  = m_ptr;
        if (e_rx)      nptr = tgt + 8'd1;
        else if (e_ld) nptr = s_mm + (e_tx ? 8'd1 : 8'd0);
        else if (e_tx) nptr = m_ptr + 8'd1;
        if (e_rx && tgt < 8'hF0) begin
            m_mem[tgt]   = s_rxd;
            m_known[tgt] = 1'b1;
            m_irq        = 1'b1;
            m_cnt        = s_clr ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
        end else if (s_clr) begin
            m_irq = 1'b0;
            m_cnt = 8'd0;
        end
        if (m_busy) begin
            m_busy = 1'b0;
        end else if (s_req && !e_rx) begin
            m_busy    = 1'b1;
            m_last_rd = !s_we;
            if (s_we) begin
                m_mem[s_ca]   = s_wd;
                m_known[s_ca] = 1'b1;
            end else begin
                m_rdata = m_mem[s_ca];
                m_rd_k  = m_known[s_ca];
            end
        end
        m_ptr  = nptr;
        m_tx   = otx;
        m_tx_k = otx_k;
        h_ld = s_ld; h_rx = s_rx; h_tx = s_tx;
    endtask

    task automatic drive();
        bus.ld = s_ld;   bus.mm_addr = s_mm;  bus.rx_done = s_rx; bus.rx_data = s_rxd;
        bus.tx_done = s_tx; bus.cpu_req = s_req; bus.cpu_we = s_we;
        bus.cpu_addr = s_ca; bus.cpu_wdata = s_wd; bus.irq_clr = s_clr;
    endtask

    task automatic idle_inputs();
        s_ld = 0; s_rx = 0; s_tx = 0; s_req = 0; s_we = 0; s_clr = 0;
        s_mm = 0; s_rxd = 0; s_ca = 0; s_wd = 0;
    endtask

    task automatic tick();
        drive();
        model_step();
        @(posedge clk);
        #1;
        chk("ptr", bus.ptr, m_ptr);
        chk("irq", bus.irq, m_irq);
        chk("wr_count", bus.wr_count, m_cnt);
        chk("cpu_ready", bus.cpu_ready, m_busy);
        if (m_tx_k) chk("tx_data", bus.tx_data, m_tx);
        if (m_busy && m_last_rd && m_rd_k) chk("cpu_rdata", bus.cpu_rdata, m_rdata);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        s_req = 1; s_we = 1; s_ca = a; s_wd = d;
        tick();
        s_req = 0; s_we = 0;
        tick();
    endtask

    task automatic cpu_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        s_req = 1; s_we = 0; s_ca = a;
        tick();
        chk(tag, bus.cpu_rdata, exp);
        s_req = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        idle_inputs();
        drive();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ptr", bus.ptr, 8'h00);
        chk("rst_tx", bus.tx_data, 8'h00);
        chk("rst_irq", bus.irq, 1'b0);
        chk("rst_cnt", bus.wr_count, 8'h00);
        chk("rst_ready", bus.cpu_ready, 1'b0);
        chk("rst_rdata", bus.cpu_rdata, 8'h00);
        reset = 1'b1;

        for (int a = 0; a < 256; a++) cpu_write(8'(a), 8'(a) ^ 8'h5A);

        // Load then three sequential writes
        s_ld = 1; s_mm = 8'h10; tick(); s_ld = 0; tick();
        for (int k = 1; k <= 3; k++) begin
            s_rx = 1; s_rxd = 8'hA0 + 8'(k); tick();
            s_rx = 0; tick();
        end
        chk("t1_ptr", bus.ptr, 8'h13);
        chk("t1_cnt", bus.wr_count, 8'd3);
        chk("t1_irq", bus.irq, 1'b1);
        cpu_read("t1_m10", 8'h10, 8'hA1);
        cpu_read("t1_m11", 8'h11, 8'hA2);
        cpu_read("t1_m12", 8'h12, 8'hA3);

        // CPU preload then I2C read-back through tx_data
        cpu_write(8'h20, 8'h55);
        cpu_write(8'h21, 8'h66);
        s_ld = 1; s_mm = 8'h20; tick(); s_ld = 0; tick();
        chk("t2_tx55", bus.tx_data, 8'h55);
        s_tx = 1; tick(); s_tx = 0; tick();
        chk("t2_tx66", bus.tx_data, 8'h66);

        // Read-only drop and pointer wrap
        s_clr = 1; tick(); s_clr = 0;
        s_ld = 1; s_mm = 8'hFF; tick(); s_ld = 0; tick();
        s_rx = 1; s_rxd = 8'h01; tick(); s_rx = 0; tick();
        s_rx = 1; s_rxd = 8'h02; tick(); s_rx = 0; tick();
        chk("t3_cnt", bus.wr_count, 8'd1);
        chk("t3_ptr", bus.ptr, 8'h01);
        cpu_read("t3_mFF", 8'hFF, 8'hA5);
        cpu_read("t3_m00", 8'h00, 8'h02);

        // CPU write colliding with an I2C write
        s_ld = 1; s_mm = 8'h60; tick(); s_ld = 0; tick();
        s_rx = 1; s_rxd = 8'h88; s_req = 1; s_we = 1; s_ca = 8'h30; s_wd = 8'h77;
        tick();
        chk("t4_wait", bus.cpu_ready, 1'b0);
        s_rx = 0; tick();
        chk("t4_ready", bus.cpu_ready, 1'b1);
        s_req = 0; s_we = 0; tick();
        cpu_read("t4_m30", 8'h30, 8'h77);
        cpu_read("t4_m60", 8'h60, 8'h88);

        // Held strobe and clear colliding with an accepted write
        s_ld = 1; s_mm = 8'h50; tick(); s_ld = 0; tick();
        s_clr = 1; tick(); s_clr = 0;
        s_rx = 1; s_rxd = 8'hC3; repeat (5) tick();
        chk("t5_once_cnt", bus.wr_count, 8'd1);
        chk("t5_once_ptr", bus.ptr, 8'h51);
        s_rx = 0; tick();
        s_rx = 1; s_clr = 1; tick();
        chk("t5_clr_irq", bus.irq, 1'b1);
        chk("t5_clr_cnt", bus.wr_count, 8'd1);
        s_rx = 0; s_clr = 0; tick();

        // Reset in the middle of a CPU read
        s_ld = 1; s_mm = 8'h44; tick(); s_ld = 0;
        s_req = 1; s_we = 0; s_ca = 8'h10; tick();
        chk("t6_pre_ptr", bus.ptr, 8'h44);
        idle_inputs();
        drive();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("t6_ptr", bus.ptr, 8'h00);
        chk("t6_tx", bus.tx_data, 8'h00);
        chk("t6_irq", bus.irq, 1'b0);
        chk("t6_cnt", bus.wr_count, 8'h00);
        chk("t6_ready", bus.cpu_ready, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk("t6_idle_ready", bus.cpu_ready, 1'b0);
        cpu_read("t6_mem", 8'h10, 8'hA1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            s_ld  = ($urandom_range(0, 7) == 0);
            s_mm  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(232, 255)) : 8'($urandom);
            s_rx  = ($urandom_range(0, 2) == 0);
            s_rxd = 8'($urandom);
            s_tx  = ($urandom_range(0, 3) == 0);
            s_clr = ($urandom_range(0, 15) == 0);
            if (m_busy) begin
                s_req = 0;
            end else if (!s_req && $urandom_range(0, 2) == 0) begin
                s_req = 1;
                s_we  = 1'($urandom_range(0, 1));
                s_ca  = 8'($urandom);
                s_wd  = 8'($urandom);
            end
            tick();
        end

        idle_inputs();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_reg_bank.md
# i2c_reg_bank

Byte-wide register bank that sits directly behind `I2C_Slave_MEM` and serves as its memory back end. It consumes the slave's `ld`/`mm_addr`, `rx_done`/`rx_data` and `tx_done` strobes, keeps an auto-incrementing byte pointer, and drives `tx_data` back to the slave. A second, CPU-side request/ready port gives the RISC-V core read/write access to the same storage. Accepted I2C writes are counted and reported through a sticky interrupt.

## Interface
- `DEPTH`, 256: number of bytes; must equal 2^`AW`.
- `AW`, 8: pointer and address width; matches `mm_addr`.
- `RO_BASE`, 8'hF0: addresses at or above this value are read-only from I2C; the CPU can still write them.
- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-low reset.
- `ld` in 1: from the slave; load the pointer from `mm_addr`.
- `mm_addr` in AW: memory address captured by the slave.
- `rx_done` in 1: from the slave; `rx_data` holds a byte written by the I2C master.
- `rx_data` in 8: received byte.
- `tx_done` in 1: from the slave; the byte on `tx_data` has been sent to the master.
- `tx_data` out 8: byte at the current pointer, returned to the slave.
- `cpu_req` in 1: CPU access request; held high until `cpu_ready`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr` in AW: CPU access address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_rdata` out 8: read data, valid while `cpu_ready` is high.
- `irq_clr` in 1: clears `irq` and `wr_count`.
- `irq` out 1: sticky; set by any accepted I2C write.
- `wr_count` out 8: accepted I2C writes since the last clear; saturates at 255.
- `ptr` out AW: current pointer, for debug and status.

## Operation
- **Edge detection.** `ld`, `rx_done` and `tx_done` each pass through a rising-edge detector (a one-flop history each). One pulse counts as one event regardless of its width.
- **Load.** On an `ld` event, `ptr` ← `mm_addr`.
- **I2C write.** On an `rx_done` event:
  - If the target address < `RO_BASE`: `mem[target]` ← `rx_data`, set `irq`, increment `wr_count` (saturating at 255).
  - If the target address ≥ `RO_BASE`: the write is dropped and nothing is counted.
  - In both cases `ptr` ← target + 1.
- **I2C read advance.** On a `tx_done` event, `ptr` ← `ptr` + 1.
- **Pointer wrap.** All pointer arithmetic is modulo 2^AW, so 8'hFF + 1 = 8'h00.
- **Simultaneous I2C events:**
  - `ld` with `rx_done`: the target address is `mm_addr`; `ptr` ← `mm_addr` + 1.
  - `ld` with `tx_done`: `ptr` ← `mm_addr` + 1.
  - `rx_done` with `tx_done`: one write, one increment.
- **CPU arbitration.** The CPU port is governed by a 2-state FSM:
  - `C_IDLE` → `C_DONE` when `cpu_req` is high and no I2C write event occurs in that cycle. The access is performed in that cycle.
  - `C_DONE` → `C_IDLE` unconditionally. `cpu_ready` = 1 in `C_DONE`.
  - An I2C write event always wins. The CPU request waits and is retried the next cycle.
  - A CPU write ignores `RO_BASE`. It does not affect `irq`, `wr_count` or `ptr`.
- **Interrupt clear.** `irq_clr` clears `irq` and zeroes `wr_count`. If an accepted I2C write occurs in the same cycle, the set wins: `irq` = 1 and `wr_count` = 1.
- **Reset.** Reset asserted at any time, including mid-transaction, returns the FSM to `C_IDLE`. It clears the following:
  - `ptr`, `tx_data`, `cpu_rdata`, `cpu_ready`, `irq`, `wr_count` → 0.
  - Edge-detector history → 0.
  - Memory contents are not reset.

## Timing
- **`tx_data` update.** `tx_data` is registered and equals `mem[ptr]` one cycle after any change to `ptr` or to `mem[ptr]`, whether written from I2C or the CPU.
  - The slave samples `tx_data` at least 50 cycles after `tx_done`/`ld`, so a 1-cycle latency is sufficient.
- **Edge-to-effect latency.** An event strobe is seen at cycle N. The pointer or memory update is visible at N+1, and `tx_data` reflects it at N+2.
- **CPU latency.**
  - Read: `cpu_req` sampled in cycle N with no conflict → `cpu_ready` and `cpu_rdata` in cycle N+1.
  - Write: visible to a read issued at N+1.
- **Back-to-back CPU access.** The CPU must drop `cpu_req` or present a new request after `cpu_ready`. At most one access completes every 2 cycles.

## Structure
- **Shared package `i2c_pkg`:** the CPU FSM state enum (`C_IDLE`, `C_DONE`), the `AW` default and the `RO_BASE` default. These are shared with `I2C_Slave_MEM`'s address width.
- **Sub-module `edge_rise`:** a one-flop rising-edge detector, instantiated three times.
- **Storage:** inferred as a flop/LUT array with an asynchronous read feeding the `tx_data` register.

## Test plan
- `ld` with `mm_addr` = 8'h10, then three `rx_done` pulses with data 8'hA1, 8'hA2, 8'hA3 → mem[10..12] = A1/A2/A3, `ptr` = 8'h13, `wr_count` = 3, `irq` = 1.
- CPU preloads mem[20] = 8'h55 and mem[21] = 8'h66. Then `ld` with 8'h20 → `tx_data` = 55 two cycles later. `tx_done` → `tx_data` = 66.
- `ld` with 8'hFF, then two `rx_done` events with 8'h01 and 8'h02 → mem[FF] stays unchanged (read-only region), mem[00] = 8'h02, `wr_count` = 1, and `ptr` wraps to 8'h01.
- CPU write to 8'h30 asserted in the same cycle as an I2C `rx_done` → the I2C write lands first, `cpu_ready` is delayed by one cycle, and both writes are present afterwards.
- `rx_done` held high for 5 cycles → exactly one write. `irq_clr` in the same cycle as an accepted write → `irq` = 1, `wr_count` = 1.
- Reset pulsed low mid-read with `ptr` = 8'h44 → `ptr`, `tx_data`, `irq`, `wr_count` = 0 and the FSM is in `C_IDLE`. A previously written memory byte is still readable by the CPU afterwards.
